// File: rtl/bin_to_bcd8.sv
// bin_to_bcd8
//
// Sequential binary-to-BCD converter for the eight-digit seven-segment
// display controller. A start pulse in IDLE captures an unsigned binary
// value. The converter then runs the shift-add-3 (double-dabble) algorithm,
// one input bit per clock. When it finishes, it loads eight registered BCD
// digits. The digit registers hold the last result between conversions, so
// the display never sees intermediate values.
//
// Parameters:
//   W        width of the binary input, legal range 4..27
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-high reset
//   start    conversion request, sampled only in IDLE
//   bin      unsigned value to convert, captured when start is accepted
//   busy     high from the accepting edge through the cycle done is shown
//   done     one-cycle pulse marking freshly loaded digits
//   overflow last captured value exceeded 99_999_999 (digits saturate to 9)
//   digit1   ones place ... digit8 tens-of-millions place, BCD, held

module bin_to_bcd8 #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic [3:0]   digit1,
  output logic [3:0]   digit2,
  output logic [3:0]   digit3,
  output logic [3:0]   digit4,
  output logic [3:0]   digit5,
  output logic [3:0]   digit6,
  output logic [3:0]   digit7,
  output logic [3:0]   digit8
);

  localparam int CW = $clog2(W);
  localparam int WW = 32 + W;
  localparam logic [31:0] MAX_DISPLAY = 32'd99_999_999;
  localparam logic [31:0] SATURATED = 32'h9999_9999;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Working register: BCD field in the top 32 bits, binary field below it.
  logic [WW-1:0] work_q, work_d;
  logic ovf_work_q, ovf_work_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic overflow_q, overflow_d;
  logic [31:0] bcd_out_q, bcd_out_d;

  logic [31:0] bcd_adj;

  // Add-3 correction on each working nibble, with no carry between nibbles.
  // A nibble of 5..9 becomes 8..12, so after the shift it carries out
  // correctly and the nibble left behind is again 0..9.
  always_comb begin
    bcd_adj = work_q[WW-1:W];
    for (int i = 0; i < 8; i++) begin
      if (work_q[W+4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = work_q[W+4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath logic. busy_d stays high through DONE. The
  // registered busy therefore covers the cycle in which done is visible.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    ovf_work_d = ovf_work_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    bcd_out_d  = bcd_out_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d     = {32'd0, bin};
          cnt_d      = CW'(W - 1);
          ovf_work_d = ({{(32-W){1'b0}}, bin} > MAX_DISPLAY);
          busy_d     = 1'b1;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        work_d = {bcd_adj[30:0], work_q[W-1:0], 1'b0};
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        bcd_out_d  = ovf_work_q ? SATURATED : work_q[WW-1:W];
        overflow_d = ovf_work_q;
        done_d     = 1'b1;
        busy_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      ovf_work_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      bcd_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      ovf_work_q <= ovf_work_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      bcd_out_q  <= bcd_out_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign digit1   = bcd_out_q[3:0];
  assign digit2   = bcd_out_q[7:4];
  assign digit3   = bcd_out_q[11:8];
  assign digit4   = bcd_out_q[15:12];
  assign digit5   = bcd_out_q[19:16];
  assign digit6   = bcd_out_q[23:20];
  assign digit7   = bcd_out_q[27:24];
  assign digit8   = bcd_out_q[31:28];

endmodule

// File: tb/tb_bin_to_bcd8.sv
// tb_bin_to_bcd8
//
// Directed bench for bin_to_bcd8 (W = 27). Each accepted conversion pushes
// its hand-computed packed BCD result and overflow flag into a queue. A
// monitor pops one entry on every done pulse and compares it. The main
// sequence checks reset values, latency, busy/done widths, hold behaviour
// and reset during a conversion.

module tb_bin_to_bcd8;

  localparam int W = 27;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;
  logic         overflow;
  logic [3:0]   digit1, digit2, digit3, digit4, digit5, digit6, digit7, digit8;

  typedef struct packed {
    logic [31:0] digits;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   vectors_applied = 0;
  int   miscompares = 0;

  bin_to_bcd8 #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .digit4   (digit4),
    .digit5   (digit5),
    .digit6   (digit6),
    .digit7   (digit7),
    .digit8   (digit8)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] all_digits();
    return {digit8, digit7, digit6, digit5, digit4, digit3, digit2, digit1};
  endfunction

  // One comparison: counts it, reports a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one start pulse from IDLE; optionally queue the expected result
  task automatic applyStimulus(input logic [W-1:0] value, input bit expect_done,
                               input logic [31:0] exp_digits, input logic exp_ovf);
    @(negedge clk);
    bin   = value;
    start = 1'b1;
    if (expect_done) exp_q.push_back('{digits: exp_digits, ovf: exp_ovf});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after an accept edge: measures edges to done, busy cycles, done cycles
  task automatic measureConversion(input string tag);
    int lat = 0;
    int busy_cycles = 0;
    int done_cycles = 0;
    bit finished = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_cycles++;
        if (lat == 0) lat = i;
      end
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_finished"}, 32'(finished), 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd28);
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd29);
    checkOutput({tag, "_done_cycles"}, 32'(done_cycles), 32'd1);
  endtask

  // Bounded wait for busy to fall
  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) checkOutput({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("result_digits", all_digits(), e.digits);
        checkOutput("result_overflow", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    logic [31:0] held;
    reset = 1'b1;
    start = 1'b1;
    bin   = 27'd5;

    // Reset held for two cycles with start high
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_overflow", 32'(overflow), 32'd0);
      checkOutput("reset_digits", all_digits(), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

    // Zero
    applyStimulus(27'd0, 1'b1, 32'h0000_0000, 1'b0);
    measureConversion("zero");

    // Largest displayable value
    applyStimulus(27'd99_999_999, 1'b1, 32'h9999_9999, 1'b0);
    measureConversion("max");

    // Mixed digits
    applyStimulus(27'd12_345_678, 1'b1, 32'h1234_5678, 1'b0);
    measureConversion("mixed");

    // Overflow saturates to all nines
    applyStimulus(27'd100_000_000, 1'b1, 32'h9999_9999, 1'b1);
    measureConversion("ovf");

    // Reset at iteration 10 of a conversion: no done, outputs cleared
    applyStimulus(27'd12_345_678, 1'b0, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_overflow", 32'(overflow), 32'd0);
    checkOutput("midreset_digits", all_digits(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("midreset_stays_idle", 32'(busy), 32'd0);

    // Fresh conversion after reset, overflow clears
    applyStimulus(27'd7, 1'b1, 32'h0000_0007, 1'b0);
    measureConversion("seven");

    // Start during SHIFT is ignored
    applyStimulus(27'd1234, 1'b1, 32'h0000_1234, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bin   = 27'd5555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle("busy_ignore");
    checkOutput("ignored_start_digits", all_digits(), 32'h0000_1234);

    // Digits hold across 100 idle cycles
    repeat (100) @(posedge clk);
    #1;
    held = all_digits();
    checkOutput("hold_digits", held, 32'h0000_1234);
    checkOutput("hold_busy", 32'(busy), 32'd0);

    // Start held high: next accept happens in the IDLE cycle after DONE
    @(negedge clk);
    bin   = 27'd42;
    start = 1'b1;
    exp_q.push_back('{digits: 32'h0000_0042, ovf: 1'b0});
    @(posedge clk);
    #1;
    bin = 27'd90_000_009;
    exp_q.push_back('{digits: 32'h9000_0009, ovf: 1'b0});
    repeat (29) @(posedge clk);
    #1;
    checkOutput("rearm_busy", 32'(busy), 32'd1);
    start = 1'b0;
    measureConversion("rearm");

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
